uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//   8N1 UART receiver: samples serial line rx at 16x oversampling and delivers each byte
//   on rx_data with a one-cycle rx_data_ready strobe.
//   Sits directly upstream of the command framer, which consumes rx_data/rx_data_ready
//   as operation, operand A, operand B byte triplets.
//   Also flags framing errors, which never produce a data strobe.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD_RATE   115200      serial bit rate, bits/s
//   OVERSAMPLE  16          oversample ticks per bit; fixed at 16, other values unsupported
//   (derived) TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor; 27 at defaults
// PORTS
//   clock          in   1  system clock, all logic on rising edge
//   reset          in   1  synchronous, active-high reset
//   rx             in   1  asynchronous serial input, idle high
//   rx_data        out  8  last correctly framed byte, LSB received first
//   rx_data_ready  out  1  one-cycle pulse: rx_data just updated
//   rx_frame_error out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//   Reset values
//   - reset=1 at a clock edge, regardless of state:
//     - rx_data=8'h00, rx_data_ready=0, rx_frame_error=0, state=IDLE.
//     - Tick, sample and bit counters cleared; synchroniser flops set to 1.
//   Input synchronisation
//   - rx passes through 2 flops (rx_s); all decisions use rx_s.
//   - This adds 2 cycles of input latency.
//   Tick generator
//   - Counts 0..TICK_DIV-1; tick=1 for one cycle on the terminal count.
//   - Held at 0 in IDLE, so sampling phase aligns to the detected start edge.
//   FSM (sample counter s counts ticks 0..15 within a bit)
//   - IDLE: rx_s==0 -> START, s=0.
//   - START: on the 8th tick (mid start bit), re-check rx_s.
//     - rx_s==0 -> DATA, s=0, bit=0.
//     - rx_s==1 -> IDLE (glitch reject; no output activity).
//   - DATA: every 16th tick (mid bit), shift rx_s into shift register MSB, shifting right.
//     - After bit index 7 -> STOP.
//   - STOP: on the 16th tick, sample rx_s.
//     - rx_s==1 -> next cycle rx_data=shift register, rx_data_ready=1 for exactly 1 cycle; -> IDLE.
//     - rx_s==0 -> next cycle rx_frame_error=1 for 1 cycle; rx_data unchanged; -> BREAK.
//   - BREAK: wait for rx_s==1, then -> IDLE.
//     - A line held low never produces repeated errors or bytes.
//   Timing
//   - Strobe occurs ~9.5 bit times after the start edge, plus 3 clock cycles.
//   - rx_data holds its value until the next valid byte.
//   - Back-to-back frames, next start bit immediately after the stop bit: IDLE is re-entered
//     mid stop bit, so no frame is lost.
//   - rx_data_ready and rx_frame_error are never high in the same cycle.
//   - No flow control: the consumer must accept the strobe in the cycle it is asserted.
// TESTING (defaults, TICK_DIV=27, bit time = 432 clocks)
//   1. After reset, send 0x55 -> exactly one rx_data_ready pulse; rx_data=8'h55;
//      rx_frame_error stays 0.
//   2. Back-to-back 0x01,0x0A,0x14 with no idle gap -> three single-cycle pulses, in order,
//      each ~4320 clocks apart; rx_data matches each byte.
//   3. Low glitch on rx of 4*27 clocks, then idle -> no strobe, no error, FSM back in IDLE.
//   4. Send 0xA5 with stop bit forced 0 and line held low 2 bit times -> one rx_frame_error
//      pulse; rx_data keeps 0x55; then idle and 0x3C -> rx_data_ready, rx_data=8'h3C.
//   5. Assert reset for 1 cycle at data bit 4 of 0xFF -> rx_data=0x00, no strobe for that
//      frame; a following 0x81 is received correctly.
//   6. Baud tolerance: send 0xC3 with bit time 425 and 439 clocks -> received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling: one-cycle strobe per correctly framed byte,
// one-cycle pulse per framing error (stop bit sampled low).
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       rx_frame_error
);

    localparam int unsigned TICK_DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_meta_d;
    logic                rx_s_q, rx_s_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          samp_q, samp_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_data_ready_q, rx_data_ready_d;
    logic                rx_frame_error_q, rx_frame_error_d;
    logic                tick;

    assign rx_data        = rx_data_q;
    assign rx_data_ready  = rx_data_ready_q;
    assign rx_frame_error = rx_frame_error_q;

    // Tick generator is parked at zero in IDLE so the sample phase follows the start edge.
    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        tick       = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = (state_q == ST_IDLE || tick) ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s_q) state_d = ST_START;
            ST_START: if (tick && samp_q == 4'd7) state_d = rx_s_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && samp_q == 4'd15 && bit_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (tick && samp_q == 4'd15) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sample counter, shifter and output strobes; sampling happens mid-bit.
    always_comb begin
        samp_d           = samp_q;
        bit_d            = bit_q;
        shift_d          = shift_q;
        rx_data_d        = rx_data_q;
        rx_data_ready_d  = 1'b0;
        rx_frame_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                samp_d = 4'd0;
                bit_d  = 3'd0;
            end
            ST_START: begin
                if (tick) samp_d = (samp_q == 4'd7) ? 4'd0 : samp_q + 4'd1;
            end
            ST_DATA: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        if (rx_s_q) begin
                            rx_data_d       = shift_q;
                            rx_data_ready_d = 1'b1;
                        end else begin
                            rx_frame_error_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                samp_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q        <= 1'b1;
            rx_s_q           <= 1'b1;
            tick_cnt_q       <= '0;
            samp_q           <= 4'd0;
            bit_q            <= 3'd0;
            shift_q          <= 8'h00;
            rx_data_q        <= 8'h00;
            rx_data_ready_q  <= 1'b0;
            rx_frame_error_q <= 1'b0;
        end else begin
            rx_meta_q        <= rx_meta_d;
            rx_s_q           <= rx_s_d;
            tick_cnt_q       <= tick_cnt_d;
            samp_q           <= samp_d;
            bit_q            <= bit_d;
            shift_q          <= shift_d;
            rx_data_q        <= rx_data_d;
            rx_data_ready_q  <= rx_data_ready_d;
            rx_frame_error_q <= rx_frame_error_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_byte;

    localparam int BIT_CLKS = 432;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_frame_error;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_cnt = 0;
    int         overlap_cnt = 0;
    int         start_cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         bit_clks;
        logic       stop_val;
        int         extra_low;
        int         exp_ready;
        int         exp_err;
        logic [7:0] exp_rx_data;
    } vec_t;

    vec_t vecs[7];

    uart_rx_byte dut (
        .clock          (clock),
        .reset          (reset),
        .rx             (rx),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_frame_error (rx_frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event log of every strobe, sampled away from the active edge.
    always @(negedge clock) begin
        if (rx_data_ready) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (rx_frame_error) ferr_cnt = ferr_cnt + 1;
        if (rx_data_ready && rx_frame_error) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual < lo || actual > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Drives one frame starting at a negedge; a low stop bit may be followed by extra low bits.
    task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_val,
                              input int extra_low);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (bit_clks) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_clks) @(negedge clock);
        end
        rx = stop_val;
        repeat (bit_clks) @(negedge clock);
        if (!stop_val) begin
            rx = 1'b0;
            repeat (extra_low * bit_clks) @(negedge clock);
        end
        rx = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int rbase, input int ebase,
                               input int exp_ready, input int exp_err,
                               input logic [7:0] exp_byte, input logic [7:0] exp_data);
        check({tag, "_ready_cnt"}, got_q.size() - rbase, exp_ready);
        check({tag, "_err_cnt"}, ferr_cnt - ebase, exp_err);
        if (exp_ready > 0)
            check({tag, "_byte"}, (got_q.size() > rbase) ? int'(got_q[rbase]) : -1, int'(exp_byte));
        check({tag, "_rx_data"}, int'(rx_data), int'(exp_data));
    endtask

    initial begin
        int         rbase;
        int         ebase;
        int         s0;
        int         bt;
        int         extra;
        logic       stopv;
        logic [7:0] b;
        logic [7:0] model_data;
        logic [7:0] b2b[3];

        vecs[0] = '{8'h55, BIT_CLKS, 1'b1, 0, 1, 0, 8'h55};
        vecs[1] = '{8'hA5, BIT_CLKS, 1'b0, 2, 0, 1, 8'h55};
        vecs[2] = '{8'h3C, BIT_CLKS, 1'b1, 0, 1, 0, 8'h3C};
        vecs[3] = '{8'hC3, 425,      1'b1, 0, 1, 0, 8'hC3};
        vecs[4] = '{8'hC3, 439,      1'b1, 0, 1, 0, 8'hC3};
        vecs[5] = '{8'h00, BIT_CLKS, 1'b1, 0, 1, 0, 8'h00};
        vecs[6] = '{8'hFF, BIT_CLKS, 1'b0, 0, 0, 1, 8'h00};
        b2b[0] = 8'h01;
        b2b[1] = 8'h0A;
        b2b[2] = 8'h14;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clock);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_ready", int'(rx_data_ready), 0);
        check("reset_ferr", int'(rx_frame_error), 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            rbase = got_q.size();
            ebase = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].bit_clks, vecs[i].stop_val, vecs[i].extra_low);
            repeat (40) @(negedge clock);
            check_frame($sformatf("vec%0d", i), rbase, ebase, vecs[i].exp_ready, vecs[i].exp_err,
                        vecs[i].data, vecs[i].exp_rx_data);
        end

        // Back-to-back frames with no idle gap.
        rbase = got_q.size();
        ebase = ferr_cnt;
        send_frame(b2b[0], BIT_CLKS, 1'b1, 0);
        s0 = start_cyc;
        send_frame(b2b[1], BIT_CLKS, 1'b1, 0);
        send_frame(b2b[2], BIT_CLKS, 1'b1, 0);
        repeat (40) @(negedge clock);
        check("b2b_ready_cnt", got_q.size() - rbase, 3);
        check("b2b_err_cnt", ferr_cnt - ebase, 0);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_byte%0d", i),
                  (got_q.size() > rbase + i) ? int'(got_q[rbase + i]) : -1, int'(b2b[i]));
        check_range("b2b_latency", (got_cyc.size() > rbase) ? got_cyc[rbase] - s0 : -1, 4100, 4114);
        for (int i = 1; i < 3; i++)
            check_range($sformatf("b2b_spacing%0d", i),
                        (got_cyc.size() > rbase + i) ? got_cyc[rbase + i] - got_cyc[rbase + i - 1] : -1,
                        4310, 4330);
        check("b2b_rx_data", int'(rx_data), 8'h14);

        // Short low glitch must be rejected at the mid-start-bit check.
        rbase = got_q.size();
        ebase = ferr_cnt;
        rx = 1'b0;
        repeat (4 * 27) @(negedge clock);
        rx = 1'b1;
        repeat (600) @(negedge clock);
        check_frame("glitch", rbase, ebase, 0, 0, 8'h00, 8'h14);

        // Reset pulse in the middle of data bit 4 aborts the frame.
        rbase = got_q.size();
        ebase = ferr_cnt;
        fork
            send_frame(8'hFF, BIT_CLKS, 1'b1, 0);
            begin
                repeat (5 * BIT_CLKS + 200) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                check("rst_mid_rx_data", int'(rx_data), 0);
            end
        join
        repeat (40) @(negedge clock);
        check_frame("rst_frame", rbase, ebase, 0, 0, 8'h00, 8'h00);
        rbase = got_q.size();
        ebase = ferr_cnt;
        send_frame(8'h81, BIT_CLKS, 1'b1, 0);
        repeat (40) @(negedge clock);
        check_frame("after_rst", rbase, ebase, 1, 0, 8'h81, 8'h81);
        model_data = 8'h81;

        // Random frames: good stop bit delivers the byte, low stop bit flags an error only.
        for (int i = 0; i < 4; i++) begin
            b     = 8'($urandom_range(0, 255));
            bt    = int'($urandom_range(425, 439));
            stopv = ($urandom_range(0, 3) != 0);
            extra = int'($urandom_range(0, 2));
            rbase = got_q.size();
            ebase = ferr_cnt;
            send_frame(b, bt, stopv, extra);
            repeat (20 + int'($urandom_range(0, 150))) @(negedge clock);
            if (stopv) model_data = b;
            check_frame($sformatf("rand%0d", i), rbase, ebase, stopv ? 1 : 0, stopv ? 0 : 1,
                        b, model_data);
        end

        check("ready_err_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
